// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 256-bit memory port between
// the instruction cache (m0) and the data cache (m1), with a sticky watchdog.
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_enable_i,
   input  logic              m0_write_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [LINE_W-1:0] m0_data_i,
   output logic              m0_ack_o,
   output logic [LINE_W-1:0] m0_data_o,
   input  logic              m1_enable_i,
   input  logic              m1_write_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [LINE_W-1:0] m1_data_i,
   output logic              m1_ack_o,
   output logic [LINE_W-1:0] m1_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              busy_o,
   output logic              err_timeout_o
);

   localparam int              WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state;
   logic              gnt;
   logic              last;
   logic [WD_W-1:0]   wd;
   logic              err;
   logic              cap_write;
   logic [ADDR_W-1:0] cap_addr;
   logic [LINE_W-1:0] cap_data;

   logic pick;
   logic busy;
   logic done;

   // On a tie the requester not served last wins.
   assign pick = (m0_enable_i && m1_enable_i) ? ~last : m1_enable_i;
   assign busy = (state == BUSY);
   assign done = busy && mem_ack_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         wd        <= '0;
         err       <= 1'b0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_enable_i || m1_enable_i) begin
                  gnt       <= pick;
                  cap_write <= pick ? m1_write_i : m0_write_i;
                  cap_addr  <= pick ? m1_addr_i  : m0_addr_i;
                  cap_data  <= pick ? m1_data_i  : m0_data_i;
                  wd        <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack_i) begin
                  last  <= gnt;
                  wd    <= '0;
                  state <= RELEASE;
               end else if (wd != WD_MAX) begin
                  // The flag is raised on the same edge the counter saturates.
                  wd <= wd + 1'b1;
                  if (wd == WD_MAX - 1'b1) begin
                     err <= 1'b1;
                  end
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign mem_enable_o  = busy;
   assign mem_write_o   = busy && cap_write;
   assign mem_addr_o    = busy ? cap_addr : '0;
   assign mem_data_o    = busy ? cap_data : '0;
   assign busy_o        = busy;
   assign err_timeout_o = err;

   assign m0_ack_o  = done && !gnt;
   assign m1_ack_o  = done && gnt;
   assign m0_data_o = (m0_ack_o && !cap_write) ? mem_data_i : '0;
   assign m1_data_o = (m1_ack_o && !cap_write) ? mem_data_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 256;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
   logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
   logic [LINE_W-1:0] m0_data_i, m1_data_i;
   logic              m0_ack_o, m1_ack_o;
   logic [LINE_W-1:0] m0_data_o, m1_data_o;
   logic              mem_enable_o, mem_write_o, mem_ack_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o, mem_data_i;
   logic              busy_o, err_timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [LINE_W-1:0] PAT_12 = {8{32'h12345678}};

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .busy_o(busy_o), .err_timeout_o(err_timeout_o)
   );

   always #5 clk = ~clk;

   // Returns 1 ns after the rising edge; inputs are driven here, checks follow #1 later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
      m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
      mem_ack_i = 0; mem_data_i = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_i = 1;
      next_cycle();
      next_cycle();
      rst_i = 0;
   endtask

   task automatic test_reset();
      rst_i = 1;
      m0_enable_i = 1; m1_enable_i = 1; m0_write_i = 1; mem_ack_i = 1;
      m0_addr_i = 32'hFFFF_FFFF; mem_data_i = PAT_A5;
      next_cycle();
      next_cycle();
      #1;
      n_checks++;
      if ({mem_enable_o, mem_write_o, busy_o, err_timeout_o, m0_ack_o, m1_ack_o} !== 6'b0) begin
         $display("FAIL reset_ctrl: got en=%b wr=%b busy=%b err=%b a0=%b a1=%b, want all 0",
                  mem_enable_o, mem_write_o, busy_o, err_timeout_o, m0_ack_o, m1_ack_o);
         n_fail++;
      end
      n_checks++;
      if (mem_addr_o !== '0 || mem_data_o !== '0 || m0_data_o !== '0 || m1_data_o !== '0) begin
         $display("FAIL reset_data: got addr=%h, want 0 on addr/data buses", mem_addr_o);
         n_fail++;
      end
      rst_i = 0;
      idle_inputs();
      mem_ack_i = 1;
      mem_data_i = PAT_A5;
      next_cycle();
      #1;
      n_checks++;
      if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || busy_o !== 1'b0) begin
         $display("FAIL idle_ack_ignored: got a0=%b a1=%b busy=%b, want 0 0 0",
                  m0_ack_o, m1_ack_o, busy_o);
         n_fail++;
      end
      mem_ack_i = 0;
   endtask

   task automatic test_m0_read();
      apply_reset();
      m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h0000_0400;
      mem_data_i = PAT_A5;
      next_cycle();
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_write_o !== 1'b0 || busy_o !== 1'b1) begin
         $display("FAIL m0_read_issue: got en=%b addr=%h wr=%b busy=%b, want 1 400 0 1",
                  mem_enable_o, mem_addr_o, mem_write_o, busy_o);
         n_fail++;
      end
      n_checks++;
      if (m0_ack_o !== 1'b0 || m0_data_o !== '0) begin
         $display("FAIL m0_read_noack: got ack=%b data=%h, want 0 and 0", m0_ack_o, m0_data_o);
         n_fail++;
      end
      repeat (9) next_cycle();
      mem_ack_i = 1;
      #1;
      n_checks++;
      if (m0_ack_o !== 1'b1 || m0_data_o !== PAT_A5 || m1_ack_o !== 1'b0 || m1_data_o !== '0) begin
         $display("FAIL m0_read_ack: got a0=%b d0=%h a1=%b, want 1 a5..a5 0",
                  m0_ack_o, m0_data_o, m1_ack_o);
         n_fail++;
      end
      next_cycle();
      mem_ack_i = 0;
      m0_enable_i = 0;
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b0 || m0_ack_o !== 1'b0 || m0_data_o !== '0 || busy_o !== 1'b0) begin
         $display("FAIL m0_read_release: got en=%b ack=%b busy=%b, want 0 0 0",
                  mem_enable_o, m0_ack_o, busy_o);
         n_fail++;
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h0000_0100;
      m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h0000_0200;
      for (int r = 0; r < 3; r++) begin
         logic              owner;
         logic [ADDR_W-1:0] exp_addr;
         logic [LINE_W-1:0] rd;
         owner    = r[0];
         exp_addr = owner ? 32'h200 : 32'h100;
         rd       = {8{r[31:0] + 32'hC0DE_0000}};
         next_cycle();
         #1;
         n_checks++;
         if (mem_enable_o !== 1'b1 || mem_addr_o !== exp_addr) begin
            $display("FAIL rr_grant_%0d: got en=%b addr=%h, want 1 %h",
                     r, mem_enable_o, mem_addr_o, exp_addr);
            n_fail++;
         end
         next_cycle();
         mem_ack_i = 1; mem_data_i = rd;
         #1;
         n_checks++;
         if (m0_ack_o !== !owner || m1_ack_o !== owner ||
             (owner ? m1_data_o : m0_data_o) !== rd ||
             (owner ? m0_data_o : m1_data_o) !== '0) begin
            $display("FAIL rr_ack_%0d: got a0=%b a1=%b, want a0=%b a1=%b",
                     r, m0_ack_o, m1_ack_o, !owner, owner);
            n_fail++;
         end
         next_cycle();
         mem_ack_i = 0;
         #1;
         n_checks++;
         if (mem_enable_o !== 1'b0) begin
            $display("FAIL rr_release_%0d: got en=%b, want 0", r, mem_enable_o);
            n_fail++;
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_write_stable();
      apply_reset();
      m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h0000_0820; m1_data_i = PAT_12;
      next_cycle();
      m1_data_i = '0; m1_write_i = 0; m1_addr_i = 32'hDEAD_BEEF;
      m0_enable_i = 1; m0_addr_i = 32'h0000_0040;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 ||
             mem_addr_o !== 32'h820 || mem_data_o !== PAT_12) begin
            $display("FAIL wr_stable_%0d: got wr=%b addr=%h data=%h, want 1 820 1234..",
                     c, mem_write_o, mem_addr_o, mem_data_o);
            n_fail++;
         end
         next_cycle();
      end
      mem_ack_i = 1;
      #1;
      n_checks++;
      if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_data_o !== '0) begin
         $display("FAIL wr_ack: got a1=%b a0=%b d1=%h, want 1 0 0", m1_ack_o, m0_ack_o, m1_data_o);
         n_fail++;
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_timeout();
      apply_reset();
      m0_enable_i = 1; m0_addr_i = 32'h0000_0C00;
      next_cycle();
      repeat (TIMEOUT - 1) next_cycle();
      #1;
      n_checks++;
      if (err_timeout_o !== 1'b0) begin
         $display("FAIL wd_early: got err=%b after %0d cycles, want 0", err_timeout_o, TIMEOUT - 1);
         n_fail++;
      end
      next_cycle();
      #1;
      n_checks++;
      if (err_timeout_o !== 1'b1 || busy_o !== 1'b1) begin
         $display("FAIL wd_set: got err=%b busy=%b after %0d cycles, want 1 1",
                  err_timeout_o, busy_o, TIMEOUT);
         n_fail++;
      end
      repeat (5) next_cycle();
      mem_ack_i = 1; mem_data_i = PAT_A5;
      #1;
      n_checks++;
      if (m0_ack_o !== 1'b1 || m0_data_o !== PAT_A5) begin
         $display("FAIL wd_late_ack: got ack=%b, want 1", m0_ack_o);
         n_fail++;
      end
      next_cycle();
      idle_inputs();
      next_cycle();
      #1;
      n_checks++;
      if (err_timeout_o !== 1'b1 || busy_o !== 1'b0) begin
         $display("FAIL wd_sticky: got err=%b busy=%b, want 1 0", err_timeout_o, busy_o);
         n_fail++;
      end
   endtask

   task automatic test_reset_in_flight();
      apply_reset();
      m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h0000_0900;
      next_cycle();
      next_cycle();
      next_cycle();
      rst_i = 1;
      m1_enable_i = 0;
      next_cycle();
      rst_i = 0;
      #1;
      n_checks++;
      if ({mem_enable_o, mem_write_o, busy_o, m0_ack_o, m1_ack_o} !== 5'b0 ||
          mem_addr_o !== '0 || mem_data_o !== '0) begin
         $display("FAIL rst_flight_outputs: got en=%b busy=%b addr=%h, want 0 0 0",
                  mem_enable_o, busy_o, mem_addr_o);
         n_fail++;
      end
      next_cycle();
      mem_ack_i = 1; mem_data_i = PAT_A5;
      #1;
      n_checks++;
      if (m1_ack_o !== 1'b0 || m1_data_o !== '0 || m0_ack_o !== 1'b0) begin
         $display("FAIL rst_late_ack: got a1=%b a0=%b, want 0 0", m1_ack_o, m0_ack_o);
         n_fail++;
      end
      next_cycle();
      mem_ack_i = 0;
      m0_enable_i = 1; m0_addr_i = 32'h0000_0A00;
      m1_enable_i = 1; m1_addr_i = 32'h0000_0B00;
      next_cycle();
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'hA00) begin
         $display("FAIL rst_then_tie: got en=%b addr=%h, want 1 a00 (m0 first)",
                  mem_enable_o, mem_addr_o);
         n_fail++;
      end
      mem_ack_i = 1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h0000_1000; m1_data_i = PAT_12;
      next_cycle();
      next_cycle();
      mem_ack_i = 1;
      #1;
      n_checks++;
      if (m1_ack_o !== 1'b1) begin
         $display("FAIL b2b_wb_ack: got a1=%b, want 1", m1_ack_o);
         n_fail++;
      end
      m1_write_i = 0; m1_addr_i = 32'h0000_2000;
      next_cycle();
      mem_ack_i = 0;
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b0 || busy_o !== 1'b0) begin
         $display("FAIL b2b_release: got en=%b, want 0", mem_enable_o);
         n_fail++;
      end
      next_cycle();
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b0) begin
         $display("FAIL b2b_idle: got en=%b, want 0", mem_enable_o);
         n_fail++;
      end
      next_cycle();
      #1;
      n_checks++;
      if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h2000 || mem_write_o !== 1'b0) begin
         $display("FAIL b2b_refill: got en=%b addr=%h wr=%b, want 1 2000 0",
                  mem_enable_o, mem_addr_o, mem_write_o);
         n_fail++;
      end
      mem_ack_i = 1; mem_data_i = PAT_A5;
      #1;
      n_checks++;
      if (m1_ack_o !== 1'b1 || m1_data_o !== PAT_A5) begin
         $display("FAIL b2b_refill_ack: got a1=%b d1=%h, want 1 a5..a5", m1_ack_o, m1_data_o);
         n_fail++;
      end
      next_cycle();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_i = 1;
      test_reset();
      test_m0_read();
      test_round_robin();
      test_write_stable();
      test_timeout();
      test_reset_in_flight();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single 256-bit data memory port between the instruction cache (m0) and the data cache (m1). It registers a granted request, drives the memory enable/write/address/data until the memory acknowledges, and routes the acknowledge and read data back to the granted requester. Ties are resolved round-robin. A watchdog flags memory transactions that never complete.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache line / memory data width
TIMEOUT, 64, cycles in BUSY without mem_ack_i before err_timeout_o sets (must be ≥2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
m0_enable_i  in  1  m0 request; held high until m0_ack_o
m0_write_i  in  1  m0 request is a write
m0_addr_i  in  ADDR_W  m0 line address
m0_data_i  in  LINE_W  m0 write data
m0_ack_o  out  1  m0 transaction complete, one cycle
m0_data_o  out  LINE_W  m0 read data, valid with m0_ack_o
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as m0 for the data cache
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  LINE_W  memory write data
mem_data_i  in  LINE_W  memory read data
mem_ack_i  in  1  memory done, one cycle
busy_o  out  1  state is BUSY
err_timeout_o  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, BUSY, RELEASE. gnt (1 bit, 0=m0, 1=m1); last (1 bit, last served); wd counter $clog2(TIMEOUT+1) bits.
- Reset (rst_i high at edge): state=IDLE, gnt=0, last=1, wd=0, err_timeout_o=0. All captured registers are cleared to 0. Outputs during and after reset: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, m*_ack_o=0, busy_o=0. Reset overrides everything, including a transaction in flight. A late mem_ack_i after reset is ignored.
- IDLE: if only mN_enable_i is high, set gnt=N. If both are high, set gnt=~last. At the same edge, capture that requester's write/addr/data into registers and go to BUSY. With no request, stay in IDLE.
- Latency: a request first seen high at edge t drives mem_enable_o high from edge t onward, so memory sees it the cycle after the request.
- BUSY: mem_enable_o=1; mem_write_o/addr/data come from the captured registers and stay stable for the whole transaction. Input changes on either requester are ignored. wd increments each cycle, saturating at TIMEOUT. When wd reaches TIMEOUT, set err_timeout_o=1; it stays set until reset. The transaction is not aborted.
- Completion: on the cycle mem_ack_i=1 in BUSY, m[gnt]_ack_o=1 (combinational), and m[gnt]_data_o=mem_data_i for reads. At the edge, set last=gnt, wd=0 and go to RELEASE. mem_ack_i outside BUSY is ignored.
- RELEASE: one cycle with mem_enable_o=0, so the memory always sees an enable deassertion between transactions. Then go to IDLE.
- Requester timing: the cache drops its enable one cycle after ack, so its stale enable is never sampled in IDLE. A requester that keeps enable high (e.g., writeback followed by refill) is re-arbitrated normally in IDLE.
- Non-granted requester: m*_ack_o=0 and m*_data_o=0 at all times. The granted requester's data_o is 0 except while its ack is asserted.
- A requester deasserting enable mid-BUSY does not cancel the transaction; the ack is still pulsed to it.
- Minimum back-to-back spacing: ack cycle, RELEASE, IDLE, then the next BUSY (3 edges from ack to the next mem_enable_o rise).

Test Plan:
1. m0 read of 0x00000400 only; memory acks 10 cycles after enable with data 0xA5..A5 -> mem_addr_o=0x400, mem_write_o=0; m0_ack_o pulses 1 cycle with m0_data_o=0xA5..A5; m1_ack_o stays 0; mem_enable_o low exactly 1 cycle after ack.
2. m0 and m1 both raise enable in the same cycle, both held, 3 rounds -> grant order m0, m1, m0; each ack goes only to its owner.
3. m1 write, addr 0x00000820, data 0x1234..; m1_data_i changed to 0 on the cycle after grant -> mem_data_o stays 0x1234.. and mem_write_o=1 until ack.
4. Memory never acks, TIMEOUT=64 -> err_timeout_o rises 64 cycles after entry to BUSY and stays set. A later ack completes normally, and err_timeout_o remains 1.
5. rst_i asserted 3 cycles into a BUSY m1 read, then memory acks 2 cycles later -> all outputs 0 from the reset edge, no m1_ack_o, state IDLE; the next simultaneous request is granted to m0.
6. m1 keeps enable high across a writeback ack into a refill while m0 is idle -> two consecutive m1 transactions with exactly one RELEASE and one IDLE cycle between them.
